// File: rtl/reversalmb_module.sv
// MBINIT.REVERSALMB initiator: init/clear-error/pattern/result/done handshakes over sideband,
// with a single lane-reversal retry when too few lanes report a correct per-lane ID.
module reversalmb_module #(
  parameter int NUM_LANES      = 16,
  parameter int PASS_THRESHOLD = 8,
  parameter int TIMEOUT_CYCLES = 8000
) (
  input  logic                 CLK,
  input  logic                 rst_n,
  input  logic                 MBINIT_REPAIRVAL_end,
  input  logic [3:0]           i_RX_SbMessage,
  input  logic                 i_msg_valid,
  input  logic [NUM_LANES-1:0] i_RX_msg_data,
  input  logic                 i_Busy_SideBand,
  input  logic                 i_falling_edge_busy,
  input  logic                 i_pattern_done,
  output logic [3:0]           o_TX_SbMessage,
  output logic                 o_ValidOutDatat_REVERSALMB,
  output logic                 o_pattern_gen_en,
  output logic                 o_lane_reversal_en,
  output logic                 o_MBINIT_REVERSALMB_end,
  output logic                 o_train_error
);

  localparam int CNT_W = $clog2(NUM_LANES + 1);
  localparam logic [CNT_W-1:0] PASS_THR = CNT_W'(PASS_THRESHOLD);
  localparam logic [15:0]      TO_LAST  = 16'(TIMEOUT_CYCLES - 1);

  localparam logic [3:0] MSG_INIT_REQ   = 4'b0001;
  localparam logic [3:0] MSG_INIT_RESP  = 4'b0010;
  localparam logic [3:0] MSG_CLR_REQ    = 4'b0011;
  localparam logic [3:0] MSG_CLR_RESP   = 4'b0100;
  localparam logic [3:0] MSG_RES_REQ    = 4'b0101;
  localparam logic [3:0] MSG_RES_RESP   = 4'b0110;
  localparam logic [3:0] MSG_DONE_REQ   = 4'b0111;
  localparam logic [3:0] MSG_DONE_RESP  = 4'b1000;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_INIT_REQ,
    ST_WAIT_RESP,
    ST_CHK_BUSY_CLR,
    ST_CLR_REQ,
    ST_PATTERN,
    ST_CHK_BUSY_RES,
    ST_RES_REQ,
    ST_EVAL,
    ST_CHK_BUSY_DONE,
    ST_DONE_REQ,
    ST_DONE,
    ST_ERROR
  } state_t;

  state_t               state_q, state_d;
  logic [3:0]           exp_resp_q, exp_resp_d;
  logic [NUM_LANES-1:0] result_q, result_d;
  logic [15:0]          timeout_cnt_q, timeout_cnt_d;
  logic                 lane_rev_q, lane_rev_d;
  logic [3:0]           tx_msg_q, tx_msg_d;
  logic                 tx_valid_q, tx_valid_d;
  logic                 pattern_en_q, pattern_en_d;
  logic                 stage_end_q, stage_end_d;
  logic                 train_err_q, train_err_d;
  logic [CNT_W-1:0]     pass_cnt;
  logic                 resp_match;
  logic                 timed_out;

  always_comb begin
    pass_cnt = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      pass_cnt = pass_cnt + CNT_W'(result_q[i]);
    end
  end

  assign resp_match = i_msg_valid && (i_RX_SbMessage == exp_resp_q);
  assign timed_out  = (timeout_cnt_q == TO_LAST);

  always_comb begin
    state_d    = state_q;
    exp_resp_d = exp_resp_q;
    result_d   = result_q;
    lane_rev_d = lane_rev_q;

    if (!MBINIT_REPAIRVAL_end) begin
      // Dropping the enable aborts from anywhere and also forgets the sticky reversal.
      state_d    = ST_IDLE;
      lane_rev_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!i_Busy_SideBand) state_d = ST_INIT_REQ;
        end
        ST_INIT_REQ: begin
          if (i_falling_edge_busy) begin
            state_d    = ST_WAIT_RESP;
            exp_resp_d = MSG_INIT_RESP;
          end
        end
        ST_WAIT_RESP: begin
          if (resp_match) begin
            case (exp_resp_q)
              MSG_INIT_RESP: state_d = ST_CHK_BUSY_CLR;
              MSG_CLR_RESP:  state_d = ST_PATTERN;
              MSG_RES_RESP: begin
                state_d  = ST_EVAL;
                result_d = i_RX_msg_data;
              end
              MSG_DONE_RESP: state_d = ST_DONE;
              default:       state_d = ST_IDLE;
            endcase
          end else if (timed_out) begin
            state_d = ST_ERROR;
          end
        end
        ST_CHK_BUSY_CLR: begin
          if (!i_Busy_SideBand) state_d = ST_CLR_REQ;
        end
        ST_CLR_REQ: begin
          if (i_falling_edge_busy) begin
            state_d    = ST_WAIT_RESP;
            exp_resp_d = MSG_CLR_RESP;
          end
        end
        ST_PATTERN: begin
          if (i_pattern_done)  state_d = ST_CHK_BUSY_RES;
          else if (timed_out)  state_d = ST_ERROR;
        end
        ST_CHK_BUSY_RES: begin
          if (!i_Busy_SideBand) state_d = ST_RES_REQ;
        end
        ST_RES_REQ: begin
          if (i_falling_edge_busy) begin
            state_d    = ST_WAIT_RESP;
            exp_resp_d = MSG_RES_RESP;
          end
        end
        ST_EVAL: begin
          if (pass_cnt >= PASS_THR) begin
            state_d = ST_CHK_BUSY_DONE;
          end else if (!lane_rev_q) begin
            state_d    = ST_CHK_BUSY_CLR;
            lane_rev_d = 1'b1;
          end else begin
            state_d = ST_ERROR;
          end
        end
        ST_CHK_BUSY_DONE: begin
          if (!i_Busy_SideBand) state_d = ST_DONE_REQ;
        end
        ST_DONE_REQ: begin
          if (i_falling_edge_busy) begin
            state_d    = ST_WAIT_RESP;
            exp_resp_d = MSG_DONE_RESP;
          end
        end
        ST_DONE:  state_d = ST_DONE;
        ST_ERROR: state_d = ST_ERROR;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    if (state_d != state_q) begin
      timeout_cnt_d = '0;
    end else if (state_q == ST_WAIT_RESP || state_q == ST_PATTERN) begin
      timeout_cnt_d = timeout_cnt_q + 16'd1;
    end else begin
      timeout_cnt_d = timeout_cnt_q;
    end
  end

  // Outputs follow the next state so they line up with the state register.
  always_comb begin
    tx_msg_d     = '0;
    tx_valid_d   = 1'b0;
    pattern_en_d = (state_d == ST_PATTERN);
    stage_end_d  = (state_d == ST_DONE);
    train_err_d  = (state_d == ST_ERROR);
    case (state_d)
      ST_INIT_REQ: begin
        tx_msg_d   = MSG_INIT_REQ;
        tx_valid_d = 1'b1;
      end
      ST_CLR_REQ: begin
        tx_msg_d   = MSG_CLR_REQ;
        tx_valid_d = 1'b1;
      end
      ST_RES_REQ: begin
        tx_msg_d   = MSG_RES_REQ;
        tx_valid_d = 1'b1;
      end
      ST_DONE_REQ: begin
        tx_msg_d   = MSG_DONE_REQ;
        tx_valid_d = 1'b1;
      end
      default: begin
        tx_msg_d   = '0;
        tx_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      exp_resp_q    <= '0;
      result_q      <= '0;
      timeout_cnt_q <= '0;
      lane_rev_q    <= 1'b0;
      tx_msg_q      <= '0;
      tx_valid_q    <= 1'b0;
      pattern_en_q  <= 1'b0;
      stage_end_q   <= 1'b0;
      train_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      exp_resp_q    <= exp_resp_d;
      result_q      <= result_d;
      timeout_cnt_q <= timeout_cnt_d;
      lane_rev_q    <= lane_rev_d;
      tx_msg_q      <= tx_msg_d;
      tx_valid_q    <= tx_valid_d;
      pattern_en_q  <= pattern_en_d;
      stage_end_q   <= stage_end_d;
      train_err_q   <= train_err_d;
    end
  end

  assign o_TX_SbMessage             = tx_msg_q;
  assign o_ValidOutDatat_REVERSALMB = tx_valid_q;
  assign o_pattern_gen_en           = pattern_en_q;
  assign o_lane_reversal_en         = lane_rev_q;
  assign o_MBINIT_REVERSALMB_end    = stage_end_q;
  assign o_train_error              = train_err_q;

endmodule
